dmem_arbiter: RTL and testbench

Two-requester arbiter for the single-port, byte-write-enabled data memory. Port 0 serves the CPU datapath's load/store path (ALU address, byte-lane `wea`, lane-aligned store data). Port 1 serves a second master such as a loader or debug engine. The block grants one access per cycle with round-robin fairness, drives the memory, and returns synchronous read data to the owning requester one cycle later.

---
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Grants are combinational; read data returns one cycle after issue.
module dmem_arbiter #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [3:0]        m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic [3:0]        m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_wea,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic        last;
    logic        rd_pend;
    logic        rd_owner;
    logic [31:0] hold0;
    logic [31:0] hold1;
    logic        is_rd;

    logic unused_addr;
    assign unused_addr = ^{m0_addr[31:MEM_AW+2], m0_addr[1:0],
                           m1_addr[31:MEM_AW+2], m1_addr[1:0]};

    // Gating with rst keeps every output low while reset is held.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                m0_gnt = last;
                m1_gnt = ~last;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wea   = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        unique case (1'b1)
            m0_gnt: begin
                mem_en    = 1'b1;
                mem_wea   = m0_we;
                mem_addr  = m0_addr[MEM_AW+1:2];
                mem_wdata = m0_wdata;
            end
            m1_gnt: begin
                mem_en    = 1'b1;
                mem_wea   = m1_we;
                mem_addr  = m1_addr[MEM_AW+1:2];
                mem_wdata = m1_wdata;
            end
            default: ;
        endcase
    end

    assign is_rd = mem_en && (mem_wea == 4'b0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last     <= 1'b1;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
            hold0    <= 32'h0;
            hold1    <= 32'h0;
        end else begin
            if (m0_req && m1_req)
                last <= m1_gnt;
            rd_pend <= is_rd;
            if (is_rd)
                rd_owner <= m1_gnt;
            if (rd_pend) begin
                if (rd_owner)
                    hold1 <= mem_rdata;
                else
                    hold0 <= mem_rdata;
            end
        end
    end

    assign m0_rvalid = rd_pend & ~rd_owner;
    assign m1_rvalid = rd_pend & rd_owner;
    assign m0_rdata  = m0_rvalid ? mem_rdata : hold0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : hold1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: predicted grants/read data are queued
// by the driver and popped by a separate monitor when rvalid appears.
module tb_dmem_arbiter;

    localparam int AW = 10;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rq [2];
    logic [3:0]    we [2];
    logic [31:0]   ad [2];
    logic [31:0]   wd [2];
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          mem_en;
    logic [3:0]    mem_wea;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;

    logic [31:0] phys [1024];
    logic [31:0] refm [1024];
    exp_t        sb [$];
    logic [31:0] hold_m [2];
    int          turn = 0;
    int          cyc_n = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    dmem_arbiter #(.MEM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(rq[0]), .m0_we(we[0]), .m0_addr(ad[0]), .m0_wdata(wd[0]),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(rq[1]), .m1_we(we[1]), .m1_addr(ad[1]), .m1_wdata(wd[1]),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_wea(mem_wea), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Synchronous single-port memory seen through the DUT's pins.
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_wea[b])
                    phys[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_en && mem_wea == 4'b0000)
            mem_rdata <= phys[mem_addr];
        else
            mem_rdata <= $urandom;
    end

    function automatic logic [31:0] init_word(int i);
        case (i)
            2:       return 32'hDEADBEEF;
            8:       return 32'h11111111;
            9:       return 32'h22222222;
            default: return 32'hC0DE0000 + 32'(i) * 32'h00010001;
        endcase
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc_n);
        end
    endtask

    // Monitor: rvalid must match the scoreboard head issued last cycle.
    always @(negedge clk) begin
        logic e [2];
        logic [31:0] rd [2];
        exp_t f;
        if (rst) begin
            hold_m[0] = 32'h0;
            hold_m[1] = 32'h0;
        end
        while (sb.size() > 0 && sb[0].cyc < cyc_n - 1) begin
            check("rvalid_missing", 1'b0, 1'b1);
            void'(sb.pop_front());
        end
        e[0] = 1'b0;
        e[1] = 1'b0;
        if (sb.size() > 0 && sb[0].cyc == cyc_n - 1) begin
            f = sb[0];
            e[f.port] = 1'b1;
        end
        rd[0] = m0_rdata;
        rd[1] = m1_rdata;
        check("m0_rvalid", m0_rvalid, e[0]);
        check("m1_rvalid", m1_rvalid, e[1]);
        for (int p = 0; p < 2; p++) begin
            if (e[p]) begin
                check(p == 0 ? "m0_rdata_rv" : "m1_rdata_rv", rd[p], f.data);
                hold_m[p] = f.data;
                void'(sb.pop_front());
            end else begin
                check(p == 0 ? "m0_rdata_hold" : "m1_rdata_hold",
                      rd[p], hold_m[p]);
            end
        end
    end

    // Reference: fair turn-taking between ports plus a word memory.
    task automatic eval(output logic [1:0] g);
        logic [1:0] e;
        int p;
        int w;
        e = 2'b00;
        if (!rst) begin
            if (rq[0] && rq[1]) begin
                e = (turn == 0) ? 2'b01 : 2'b10;
                turn = 1 - turn;
            end else begin
                e = {rq[1], rq[0]};
            end
        end
        check("m0_gnt", m0_gnt, e[0]);
        check("m1_gnt", m1_gnt, e[1]);
        if (e != 2'b00) begin
            p = e[1] ? 1 : 0;
            w = int'(ad[p][11:2]);
            check("mem_en", mem_en, 1'b1);
            check("mem_wea", mem_wea, we[p]);
            check("mem_addr", mem_addr, ad[p][11:2]);
            check("mem_wdata", mem_wdata, wd[p]);
            if (we[p] == 4'b0000) begin
                sb.push_back('{port: p, data: refm[w], cyc: cyc_n});
            end else begin
                for (int b = 0; b < 4; b++)
                    if (we[p][b])
                        refm[w][8*b +: 8] = wd[p][8*b +: 8];
            end
        end else begin
            check("mem_idle", {mem_en, mem_wea, mem_addr, mem_wdata}, 64'h0);
        end
        g = e;
    endtask

    task automatic step(output logic [1:0] g);
        @(negedge clk);
        eval(g);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int p, logic [3:0] w, logic [31:0] a,
                         logic [31:0] d);
        logic [1:0] g;
        g = 2'b00;
        rq[p] = 1'b1;
        we[p] = w;
        ad[p] = a;
        wd[p] = d;
        for (int i = 0; i < 4; i++) begin
            step(g);
            if (g[p]) break;
        end
        check("grant_timeout", g[p], 1'b1);
        rq[p] = 1'b0;
    endtask

    task automatic apply_reset();
        logic [1:0] g;
        rst = 1'b1;
        sb.delete();
        turn = 0;
        @(posedge clk);
        #1;
        step(g);
        rst = 1'b0;
    endtask

    task automatic new_req(int p);
        logic [31:0] a;
        rq[p] = ($urandom_range(0, 9) < 7);
        a = $urandom;
        a[11:2] = 10'($urandom_range(0, 15));
        ad[p] = a;
        we[p] = ($urandom_range(0, 1) == 0) ? 4'b0000
                                             : 4'($urandom_range(1, 15));
        wd[p] = $urandom;
    endtask

    initial begin
        logic [1:0] g;
        for (int i = 0; i < 1024; i++) begin
            phys[i] = init_word(i);
            refm[i] = init_word(i);
        end
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0;
            we[p] = 4'b0000;
            ad[p] = 32'h0;
            wd[p] = 32'h0;
        end
        hold_m[0] = 32'h0;
        hold_m[1] = 32'h0;
        rst = 1'b1;

        // Requests during reset must not be granted.
        rq[0] = 1'b1;
        rq[1] = 1'b1;
        step(g);
        step(g);
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        rst = 1'b0;
        step(g);

        // Reset arriving mid-read drops the pending return.
        rq[0] = 1'b1;
        ad[0] = 32'h8;
        @(negedge clk);
        eval(g);
        #2;
        rst = 1'b1;
        sb.delete();
        turn = 0;
        rq[0] = 1'b0;
        #1;
        check("rst_m0_gnt", m0_gnt, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        @(posedge clk);
        #1;
        step(g);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(g);
        check("rst_m0_rdata", m0_rdata, 32'h0);

        // Single read of 0x8, then held data.
        issue(0, 4'b0000, 32'h0000_0008, 32'h0);
        step(g);
        step(g);
        check("read_hold", m0_rdata, 32'hDEADBEEF);

        // Byte store from port 1.
        issue(1, 4'b0100, 32'h0000_0012, 32'h00AB0000);
        step(g);

        // Contention from reset: strict alternation.
        apply_reset();
        rq[0] = 1'b1; we[0] = 4'b0000; ad[0] = 32'h40;
        rq[1] = 1'b1; we[1] = 4'b0000; ad[1] = 32'h80;
        for (int i = 0; i < 6; i++) begin
            step(g);
            check("contention_order", g, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (g[0]) ad[0] = ad[0] + 32'h4;
            if (g[1]) ad[1] = ad[1] + 32'h4;
        end
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        step(g);

        // Port 0 read followed immediately by port 1 write.
        issue(0, 4'b0000, 32'h0000_0014, 32'h0);
        issue(1, 4'b0011, 32'h0000_0014, 32'h0000BEEF);
        issue(0, 4'b0000, 32'h0000_0014, 32'h0);
        step(g);

        // Hold registers stay per-port.
        issue(1, 4'b0000, 32'h0000_0020, 32'h0);
        issue(0, 4'b0000, 32'h0000_0024, 32'h0);
        step(g);
        check("hold_iso_m1", m1_rdata, 32'h11111111);
        check("hold_iso_m0", m0_rdata, 32'h22222222);

        // Randomized traffic with hold-until-grant requesters.
        g = 2'b11;
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        for (int i = 0; i < 500; i++) begin
            for (int p = 0; p < 2; p++)
                if (!rq[p] || g[p]) new_req(p);
            step(g);
        end
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        step(g);
        step(g);
        check("sb_drain", 64'(sb.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
